// File: rtl/max_pool_grp_sched_pkg.sv
// Shared definitions for the max-pool group scheduler: tree latency, legal lane
// counts, group FSM encoding and the per-beat tag carried alongside the tree.
package max_pool_grp_sched_pkg;

  localparam int MAX_TREE_LAT   = 2;
  localparam int MAX_TREE_LANES = 32;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    IN_GRP = 1'b1
  } grp_state_e;

  typedef struct packed {
    logic vld;
    logic first;
    logic last;
  } grp_tag_t;

  function automatic logic cmp_n_legal(input int n);
    case (n)
      32'sd2, 32'sd4, 32'sd8, 32'sd16, 32'sd32: return 1'b1;
      default:                                  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/max_pool_grp_sched_if.sv
// Beat-in / result-out valid-ready bundle between the line buffer, the
// scheduler and the pooling write-back.
interface max_pool_grp_sched_if #(
  parameter int CMP_INPUT_N = 8,
  parameter int CMP_WIDTH   = 8
);

  logic [CMP_INPUT_N*CMP_WIDTH-1:0] s_data;
  logic                             s_valid;
  logic                             s_ready;
  logic signed [CMP_WIDTH-1:0]      m_data;
  logic                             m_valid;
  logic                             m_ready;

  modport slave (
    input  s_data, s_valid, m_ready,
    output s_ready, m_data, m_valid
  );

  modport master (
    output s_data, s_valid, m_ready,
    input  s_ready, m_data, m_valid
  );

endinterface

// File: rtl/max_pool_grp_sched_tree.sv
// Two-stage pipelined signed max tree over up to 32 lanes; unused lanes are
// padded with the most negative value so they never win.
module max_tree_2_4_8_16_32
  import max_pool_grp_sched_pkg::*;
#(
  parameter int CMP_INPUT_N = 8,
  parameter int CMP_WIDTH   = 8
) (
  input  logic                             aclk,
  input  logic                             areset,
  input  logic                             aclken,
  input  logic [CMP_INPUT_N*CMP_WIDTH-1:0] cmp_in,
  input  logic                             cmp_in_vld,
  output logic signed [CMP_WIDTH-1:0]      cmp_out,
  output logic                             cmp_out_vld
);

  localparam int PARTS    = 4;
  localparam int PART_LEN = MAX_TREE_LANES / PARTS;
  localparam logic signed [CMP_WIDTH-1:0] NEG_MIN = {1'b1, {(CMP_WIDTH-1){1'b0}}};

  logic signed [CMP_WIDTH-1:0] lane_s [MAX_TREE_LANES];
  logic signed [CMP_WIDTH-1:0] part_s [PARTS];
  logic signed [CMP_WIDTH-1:0] part_r [PARTS];
  logic signed [CMP_WIDTH-1:0] top_s;
  logic                        stg1_vld_r;

  function automatic logic signed [CMP_WIDTH-1:0] smax(
    input logic signed [CMP_WIDTH-1:0] a,
    input logic signed [CMP_WIDTH-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

  for (genvar g = 0; g < MAX_TREE_LANES; g++) begin : g_lane
    if (g < CMP_INPUT_N) begin : g_used
      assign lane_s[g] = $signed(cmp_in[g*CMP_WIDTH +: CMP_WIDTH]);
    end else begin : g_pad
      assign lane_s[g] = NEG_MIN;
    end
  end

  // First level: reduce each group of eight lanes to one partial maximum.
  always_comb begin
    for (int p = 0; p < PARTS; p++) begin
      logic signed [CMP_WIDTH-1:0] m;
      m = lane_s[p*PART_LEN];
      for (int l = 1; l < PART_LEN; l++) begin
        m = smax(m, lane_s[p*PART_LEN+l]);
      end
      part_s[p] = m;
    end
  end

  assign top_s = smax(smax(part_r[0], part_r[1]), smax(part_r[2], part_r[3]));

  // Pipeline registers, all frozen together while aclken is low.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int p = 0; p < PARTS; p++) begin
        part_r[p] <= '0;
      end
      stg1_vld_r  <= 1'b0;
      cmp_out     <= '0;
      cmp_out_vld <= 1'b0;
    end else if (aclken) begin
      for (int p = 0; p < PARTS; p++) begin
        part_r[p] <= part_s[p];
      end
      stg1_vld_r  <= cmp_in_vld;
      cmp_out     <= top_s;
      cmp_out_vld <= stg1_vld_r;
    end
  end

endmodule

// File: rtl/max_pool_grp_sched.sv
// Group scheduler: counts input beats into groups, tags them through the max
// tree and folds the per-beat maxima into one signed result per group.
module max_pool_grp_sched
  import max_pool_grp_sched_pkg::*;
#(
  parameter int CMP_INPUT_N = 8,
  parameter int CMP_WIDTH   = 8,
  parameter int GRP_LEN_W   = 8,
  parameter int SIM_DELAY   = 1
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic [GRP_LEN_W-1:0] cfg_grp_len,
  max_pool_grp_sched_if.slave  bus,
  output logic                 busy
);

  localparam logic [GRP_LEN_W-1:0] LEN_ONE = GRP_LEN_W'(1'b1);

  if (!cmp_n_legal(CMP_INPUT_N) || (SIM_DELAY < 0)) begin : g_param_err
  end

  grp_state_e                  state_r, state_nxt_s;
  logic [GRP_LEN_W-1:0]        cnt_r, cnt_nxt_s;
  logic [GRP_LEN_W-1:0]        len_r, len_nxt_s;
  grp_tag_t                    tag_r [MAX_TREE_LAT];
  grp_tag_t                    tag_in_s;
  grp_tag_t                    tag_o_s;
  logic                        ready_en_r;
  logic                        stall_s;
  logic                        accept_s;
  logic                        busy_r, busy_nxt_s;
  logic signed [CMP_WIDTH-1:0] cmp_out_s;
  logic                        cmp_out_vld_s;
  logic                        out_vld_s;
  logic signed [CMP_WIDTH-1:0] acc_r;
  logic signed [CMP_WIDTH-1:0] res_s;
  logic signed [CMP_WIDTH-1:0] m_data_r;
  logic                        m_valid_r;

  // A held result blocks everything upstream so nothing can overwrite it.
  assign stall_s     = m_valid_r & ~bus.m_ready;
  assign bus.s_ready = ready_en_r & ~stall_s;
  assign accept_s    = bus.s_valid & bus.s_ready;
  assign tag_o_s     = tag_r[MAX_TREE_LAT-1];
  assign out_vld_s   = cmp_out_vld_s & ~stall_s;
  assign bus.m_data  = m_data_r;
  assign bus.m_valid = m_valid_r;
  assign busy        = busy_r;

  max_tree_2_4_8_16_32 #(
    .CMP_INPUT_N (CMP_INPUT_N),
    .CMP_WIDTH   (CMP_WIDTH)
  ) u_tree (
    .aclk        (aclk),
    .areset      (areset),
    .aclken      (~stall_s),
    .cmp_in      (bus.s_data),
    .cmp_in_vld  (accept_s),
    .cmp_out     (cmp_out_s),
    .cmp_out_vld (cmp_out_vld_s)
  );

  // Group counting and first/last tagging of each accepted beat.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    len_nxt_s   = len_r;
    tag_in_s    = '0;
    if (accept_s) begin
      tag_in_s.vld = 1'b1;
      case (state_r)
        IDLE: begin
          len_nxt_s      = (cfg_grp_len == '0) ? LEN_ONE : cfg_grp_len;
          tag_in_s.first = 1'b1;
          if (len_nxt_s == LEN_ONE) begin
            tag_in_s.last = 1'b1;
            state_nxt_s   = IDLE;
            cnt_nxt_s     = '0;
          end else begin
            state_nxt_s = IN_GRP;
            cnt_nxt_s   = LEN_ONE;
          end
        end
        IN_GRP: begin
          if (cnt_r == (len_r - LEN_ONE)) begin
            tag_in_s.last = 1'b1;
            state_nxt_s   = IDLE;
            cnt_nxt_s     = '0;
          end else begin
            state_nxt_s = IN_GRP;
            cnt_nxt_s   = cnt_r + LEN_ONE;
          end
        end
        default: begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = '0;
        end
      endcase
    end else begin
      tag_in_s = '0;
    end
  end

  // Busy is registered from the next-state view of the counter and tags.
  always_comb begin
    busy_nxt_s = (cnt_nxt_s != '0);
    if (stall_s) begin
      for (int i = 0; i < MAX_TREE_LAT; i++) begin
        busy_nxt_s = busy_nxt_s | tag_r[i].vld;
      end
    end else begin
      busy_nxt_s = busy_nxt_s | tag_in_s.vld;
      for (int i = 0; i < MAX_TREE_LAT-1; i++) begin
        busy_nxt_s = busy_nxt_s | tag_r[i].vld;
      end
    end
  end

  // Fold the tree output into the running maximum of the group.
  always_comb begin
    if (tag_o_s.first) begin
      res_s = cmp_out_s;
    end else begin
      res_s = (acc_r > cmp_out_s) ? acc_r : cmp_out_s;
    end
  end

  // Group FSM, tag pipeline and s_ready enable.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      len_r      <= '0;
      busy_r     <= 1'b0;
      ready_en_r <= 1'b0;
      for (int i = 0; i < MAX_TREE_LAT; i++) begin
        tag_r[i] <= '0;
      end
    end else begin
      state_r    <= state_nxt_s;
      cnt_r      <= cnt_nxt_s;
      len_r      <= len_nxt_s;
      busy_r     <= busy_nxt_s;
      ready_en_r <= 1'b1;
      if (!stall_s) begin
        tag_r[0] <= tag_in_s;
        for (int i = 1; i < MAX_TREE_LAT; i++) begin
          tag_r[i] <= tag_r[i-1];
        end
      end
    end
  end

  // Accumulator and result register.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      acc_r     <= '0;
      m_data_r  <= '0;
      m_valid_r <= 1'b0;
    end else begin
      if (out_vld_s && tag_o_s.last) begin
        m_data_r  <= res_s;
        m_valid_r <= 1'b1;
      end else if (bus.m_ready) begin
        m_valid_r <= 1'b0;
      end
      if (out_vld_s && !tag_o_s.last) begin
        acc_r <= res_s;
      end
    end
  end

endmodule

// File: tb/tb_max_pool_grp_sched.sv
// Directed bench for max_pool_grp_sched: a table of single-group vectors plus
// hand-written sequences for backpressure, mid-group config change and reset.
module tb_max_pool_grp_sched;

  logic       aclk = 1'b0;
  logic       areset = 1'b1;
  logic [7:0] cfg_grp_len = 8'd1;
  logic       busy;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         vcnt = 0;
  int         got_d [$];
  int         got_t [$];

  max_pool_grp_sched_if #(.CMP_INPUT_N(8), .CMP_WIDTH(8)) bus ();

  max_pool_grp_sched #(
    .CMP_INPUT_N (8),
    .CMP_WIDTH   (8),
    .GRP_LEN_W   (8),
    .SIM_DELAY   (1)
  ) dut (
    .aclk        (aclk),
    .areset      (areset),
    .cfg_grp_len (cfg_grp_len),
    .bus         (bus),
    .busy        (busy)
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk) cyc <= cyc + 1;

  always @(negedge aclk) begin
    if (!areset && bus.m_valid) begin
      vcnt <= vcnt + 1;
      if (bus.m_ready) begin
        got_d.push_back(int'($signed(bus.m_data)));
        got_t.push_back(cyc);
      end
    end
  end

  typedef struct {
    string       name;
    int          len_cfg;
    int          nbeats;
    logic [63:0] beat [4];
    int          exp_max;
  } vec_t;

  vec_t vec [6];

  function automatic logic [63:0] mk(input int l0, input int l1, input int l2, input int l3,
                                     input int l4, input int l5, input int l6, input int l7);
    return {8'(l7), 8'(l6), 8'(l5), 8'(l4), 8'(l3), 8'(l2), 8'(l1), 8'(l0)};
  endfunction

  task automatic set_vec(input int i, input string nm, input int len, input int n,
                         input logic [63:0] b0, input logic [63:0] b1,
                         input logic [63:0] b2, input logic [63:0] b3, input int e);
    vec[i].name    = nm;
    vec[i].len_cfg = len;
    vec[i].nbeats  = n;
    vec[i].beat[0] = b0;
    vec[i].beat[1] = b1;
    vec[i].beat[2] = b2;
    vec[i].beat[3] = b3;
    vec[i].exp_max = e;
  endtask

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Present one beat and hold it until accepted; t is the accept cycle.
  task automatic send_beat(input logic [63:0] d, output int t);
    int  n;
    logic ok;
    n = 0;
    ok = 1'b0;
    t = 0;
    bus.s_data  = d;
    bus.s_valid = 1'b1;
    while (!ok && n < 200) begin
      @(negedge aclk);
      ok = bus.s_ready;
      t  = cyc;
      @(posedge aclk);
      #1;
      n++;
    end
    bus.s_valid = 1'b0;
    if (!ok) chk("beat_accept_timeout", 0, 1);
  endtask

  task automatic wait_results(input int n, input int bound);
    int k;
    k = 0;
    while (got_d.size() < n && k < bound) begin
      @(posedge aclk);
      #1;
      k++;
    end
    chk("result_arrived", (got_d.size() >= n) ? 1 : 0, 1);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  initial begin
    int t_last;
    int t_fourth;
    int exp4 [4];
    logic [63:0] bp [8];

    set_vec(0, "len1_single", 1, 1, mk(3, -7, 12, 0, 5, -1, 9, 2), 64'd0, 64'd0, 64'd0, 12);
    set_vec(1, "len3_stream", 3, 3, mk(4, 1, 0, -3, 2, 3, -8, 4),
            mk(-2, -5, -128, -3, -9, -2, -100, -4), mk(17, 0, 16, -1, 5, 5, 5, 5), 64'd0, 17);
    set_vec(2, "all_min_len2", 2, 2, mk(-128, -128, -128, -128, -128, -128, -128, -128),
            mk(-128, -128, -128, -128, -128, -128, -128, -128), 64'd0, 64'd0, -128);
    set_vec(3, "cfg0_as_len1", 0, 1, mk(-1, -2, -3, -4, -5, -6, -7, -8), 64'd0, 64'd0, 64'd0, -1);
    set_vec(4, "len4_first_wins", 4, 4, mk(0, 0, 0, 0, 0, 0, 0, 127),
            mk(10, -1, -1, -1, -1, -1, -1, -1), mk(-5, -6, -7, -8, -9, -10, -11, -12),
            mk(0, 0, 0, 0, 0, 0, 0, 0), 127);
    set_vec(5, "len2_neg_fold", 2, 2, mk(-50, -60, -70, -80, -90, -100, -110, -120),
            mk(-51, -52, -53, -54, -55, -56, -57, -58), 64'd0, 64'd0, -50);

    bus.s_data  = 64'd0;
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;

    // Reset state.
    @(negedge aclk);
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_m_data", bus.m_data, 0);
    chk("rst_busy", busy, 0);
    @(posedge aclk);
    #1;
    areset = 1'b0;
    @(posedge aclk);
    #1;
    chk("s_ready_after_release", bus.s_ready, 1);

    // Table-driven single groups with m_ready held high.
    for (int v = 0; v < 6; v++) begin
      got_d.delete();
      got_t.delete();
      vcnt = 0;
      cfg_grp_len = 8'(vec[v].len_cfg);
      t_last = 0;
      for (int b = 0; b < vec[v].nbeats; b++) begin
        send_beat(vec[v].beat[b], t_last);
        if (b == 0 && vec[v].nbeats > 1) chk({vec[v].name, "_busy_mid"}, busy, 1);
      end
      wait_results(1, 20);
      if (got_d.size() >= 1) begin
        chk({vec[v].name, "_data"}, got_d[0], vec[v].exp_max);
        chk({vec[v].name, "_latency"}, got_t[0], t_last + 3);
      end
      idle_cycles(5);
      chk({vec[v].name, "_count"}, got_d.size(), 1);
      chk({vec[v].name, "_valid_cycles"}, vcnt, 1);
      chk({vec[v].name, "_busy_after"}, busy, 0);
    end

    // Backpressure: four len-2 groups, m_ready dropped after the first result.
    got_d.delete();
    got_t.delete();
    cfg_grp_len = 8'd2;
    bp[0] = mk(11, 0, 0, 0, 0, 0, 0, 0);
    bp[1] = mk(5, 5, 5, 5, 5, 5, 5, -128);
    bp[2] = mk(0, 0, 0, 0, 0, 0, 0, 0);
    bp[3] = mk(1, 2, 3, 22, 4, 5, 6, 7);
    bp[4] = mk(-3, -3, -3, -3, -3, -3, -3, -3);
    bp[5] = mk(-9, -8, -7, -6, -5, -4, -10, -100);
    bp[6] = mk(0, 0, 0, 0, 0, 0, 0, 127);
    bp[7] = mk(126, 1, 1, 1, 1, 1, 1, 1);
    exp4[0] = 11;
    exp4[1] = 22;
    exp4[2] = -3;
    exp4[3] = 127;
    fork
      begin
        int tb;
        for (int i = 0; i < 8; i++) send_beat(bp[i], tb);
      end
      begin
        int k;
        k = 0;
        while (got_d.size() < 1 && k < 50) begin
          @(posedge aclk);
          #1;
          k++;
        end
        bus.m_ready = 1'b0;
        repeat (6) @(posedge aclk);
        @(negedge aclk);
        chk("bp_s_ready_low", bus.s_ready, 0);
        chk("bp_m_valid_held", bus.m_valid, 1);
        chk("bp_m_data_held", int'($signed(bus.m_data)), 22);
        chk("bp_busy_frozen", busy, 1);
        repeat (3) @(negedge aclk);
        chk("bp_m_data_still", int'($signed(bus.m_data)), 22);
        chk("bp_no_extra", got_d.size(), 1);
        @(posedge aclk);
        #1;
        bus.m_ready = 1'b1;
      end
    join
    wait_results(4, 100);
    idle_cycles(5);
    chk("bp_count", got_d.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < got_d.size()) chk($sformatf("bp_result%0d", i), got_d[i], exp4[i]);
    end

    // Length changed mid-group only applies to the next group.
    got_d.delete();
    got_t.delete();
    cfg_grp_len = 8'd4;
    send_beat(mk(1, 1, 1, 1, 1, 1, 1, 1), t_last);
    send_beat(mk(0, 0, 40, 0, 0, 0, 0, 0), t_last);
    cfg_grp_len = 8'd2;
    send_beat(mk(-1, -1, -1, -1, -1, -1, -1, -1), t_last);
    send_beat(mk(2, 2, 2, 2, 2, 2, 2, 2), t_fourth);
    send_beat(mk(-60, -60, -60, -60, -60, -60, -60, -60), t_last);
    send_beat(mk(-61, -61, -61, -59, -61, -61, -61, -61), t_last);
    wait_results(2, 30);
    idle_cycles(5);
    chk("cfg_count", got_d.size(), 2);
    if (got_d.size() >= 2) begin
      chk("cfg_grp4_data", got_d[0], 40);
      chk("cfg_grp4_latency", got_t[0], t_fourth + 3);
      chk("cfg_grp2_data", got_d[1], -59);
      chk("cfg_grp2_latency", got_t[1], t_last + 3);
    end

    // Reset after two of three beats discards the partial group.
    got_d.delete();
    got_t.delete();
    cfg_grp_len = 8'd3;
    send_beat(mk(100, 100, 100, 100, 100, 100, 100, 100), t_last);
    send_beat(mk(90, 90, 90, 90, 90, 90, 90, 90), t_last);
    areset = 1'b1;
    @(negedge aclk);
    chk("mid_rst_m_valid", bus.m_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_m_data", bus.m_data, 0);
    idle_cycles(2);
    areset = 1'b0;
    idle_cycles(1);
    chk("mid_rst_s_ready", bus.s_ready, 1);
    send_beat(mk(5, 0, 0, 0, 0, 0, 0, 0), t_last);
    send_beat(mk(0, 7, 0, 0, 0, 0, 0, 0), t_last);
    send_beat(mk(0, 0, 6, 0, 0, 0, 0, 0), t_last);
    wait_results(1, 20);
    idle_cycles(6);
    chk("post_rst_count", got_d.size(), 1);
    if (got_d.size() >= 1) begin
      chk("post_rst_data", got_d[0], 7);
      chk("post_rst_latency", got_t[0], t_last + 3);
    end
    chk("post_rst_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/max_pool_grp_sched.md
Name: max_pool_grp_sched

Overview:
- Scheduler that drives a pipelined signed max tree (`max_tree_2_4_8_16_32`, 2-cycle latency, global clock enable) to reduce a group of multi-lane input beats to one signed maximum.
- Accepts beats over a valid/ready stream and counts them into groups of configurable length.
- Folds the tree's per-beat results into a running maximum and emits one result per group on a valid/ready output.
- Sits between the feature-map line buffer and the pooling write-back in the max-pool path.

Parameters:
- CMP_INPUT_N, 8, lanes per beat (2 | 4 | 8 | 16 | 32), passed to the tree.
- CMP_WIDTH, 8, signed compare width.
- GRP_LEN_W, 8, width of the group-length configuration.
- SIM_DELAY, 1, simulation delay on register updates.

Ports:
- aclk  in  1  clock.
- areset  in  1  asynchronous active-high reset.
- cfg_grp_len  in  GRP_LEN_W  beats per group; 0 is treated as 1.
- s_data  in  CMP_INPUT_N*CMP_WIDTH  input lanes, lane i at bits [(i+1)*W-1 : i*W].
- s_valid  in  1  input beat valid.
- s_ready  out  1  input beat ready.
- m_data  out  CMP_WIDTH  signed group maximum.
- m_valid  out  1  result valid.
- m_ready  in  1  result ready.
- busy  out  1  a group is partially accepted or beats are in flight.

Behaviour:
- Reset, asynchronous and active-high. Clears:
  - m_valid=0, m_data=0, busy=0;
  - beat counter=0, latched length=0, tag pipeline=0, accumulator=0.
  - s_ready=1 from the first clock after reset release.
  - Reset mid-group discards partial results; no output is produced for that group.
- Stall and enable:
  - stall = m_valid & ~m_ready.
  - tree aclken = ~stall; s_ready = ~stall.
  - When stalled, the tree, the tag pipeline and the accumulator all freeze.
- Beat accept: s_valid & s_ready.
  - Tree cmp_in = s_data.
  - Tree cmp_in_vld = s_valid & s_ready.
- Group FSM:
  - IDLE (counter=0): on accept, latch len = max(cfg_grp_len,1) and tag first=1. If len==1, also tag last=1 and stay IDLE; otherwise go to IN_GRP with counter=1.
  - IN_GRP: on each accept, counter+1. When counter==len-1, tag last=1, clear the counter and return to IDLE.
  - cfg_grp_len changes take effect only at the next group start.
- Tag pipeline: 2-stage {first,last} shift register, advanced under the same enable as the tree, aligned with cmp_out_vld.
- Accumulate on cmp_out_vld & ~stall:
  - first & ~last: acc <= out.
  - ~first & ~last: acc <= max(acc,out), signed.
  - last: m_data <= first ? out : max(acc,out), and m_valid <= 1.
- Output:
  - m_valid clears on m_ready when no new result arrives that cycle.
  - A result arriving in the same cycle as m_ready keeps m_valid=1 with the new data.
  - No result is ever dropped or overwritten while m_valid & ~m_ready.
- Latency: last beat accepted at cycle T -> tree out at T+2 -> m_valid at T+3, given no stall.
- Throughput: one beat per cycle sustained while m_ready=1.
- busy = (counter!=0) | any tag valid in the pipeline.
- Unused tree lanes are padded by the tree with -2^(W-1). The scheduler adds no extra padding.
- Ties give the same value, so lane order does not matter.

Decomposition:
- Shared package holds:
  - allowed CMP_INPUT_N set;
  - tree latency constant MAX_TREE_LAT=2;
  - FSM state encoding {IDLE, IN_GRP}.
- One sub-module: the existing max tree, instanced with aclken driven by ~stall.
- Tag pipeline and accumulator stay in the top level.

Test Plan:
- N=8, W=8, len=1, single beat lanes {3,-7,12,0,5,-1,9,2}, m_ready=1 -> m_data=12 at T+3; m_valid one cycle.
- len=3, beats with lane maxima 4, -2, 17 sent back-to-back -> one result 17 at T_last+3; busy=1 during the group and back to 0 after.
- All lanes -128 over len=2 -> m_data=-128 (signed min handled); cfg_grp_len=0 behaves as len=1.
- len=2, 4 groups streamed, m_ready held 0 after the first result -> s_ready=0 and the pipeline frozen. Release m_ready -> remaining results 2nd..4th emitted in order, none lost.
- cfg_grp_len changed from 4 to 2 mid-group -> current group still closes after 4 beats, the next after 2.
- areset pulsed after 2 of 3 beats -> m_valid=0, busy=0. The next 3 beats produce exactly one correct result.
